// File: rtl/accessor_scheduler_if.sv
// Accessor-side handshake bundle: start/count towards the BRAM accessor, idle/done back.
interface accessor_scheduler_if #(
    parameter int CNT_BIT = 31
);
    logic               acc_idle_i;
    logic               acc_done_i;
    logic               acc_start_o;
    logic [CNT_BIT-1:0] acc_count_o;

    modport master (
        input  acc_idle_i,
        input  acc_done_i,
        output acc_start_o,
        output acc_count_o
    );

    modport slave (
        output acc_idle_i,
        output acc_done_i,
        input  acc_start_o,
        input  acc_count_o
    );
endinterface

// File: rtl/accessor_scheduler.sv
// Round-robin scheduler sharing one BRAM accessor between two requesters,
// with a wait-state watchdog and per-job status/elapsed-cycle report.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for an idle accessor and a request
// S_START   | one-cycle start pulse and ack to the winner
// S_WAIT_BUSY | accessor started, waiting for it to leave idle or finish
// S_WAIT_DONE | accessor running, waiting for done or watchdog
// S_RESP    | one-cycle done pulse with status/cycles to the owner
module accessor_scheduler #(
    parameter int CNT_BIT     = 31,
    parameter int CYC_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_i,
    input  logic [CNT_BIT-1:0] cnt0_i,
    output logic               ack0_o,
    output logic               done0_o,
    input  logic               req1_i,
    input  logic [CNT_BIT-1:0] cnt1_i,
    output logic               ack1_o,
    output logic               done1_o,
    output logic [1:0]         status_o,
    output logic [CYC_W-1:0]   cycles_o,
    accessor_scheduler_if.master acc,
    output logic               busy_o,
    output logic               grant_o
);

    localparam logic [CYC_W-1:0] CYC_MAX   = '1;
    localparam logic [CYC_W-1:0] TIMEOUT_V = CYC_W'(TIMEOUT_CYC);
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ZERO    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t             state;
    logic               last_grant;
    logic [CYC_W-1:0]   cyc_cnt;

    logic               pick1;
    logic               grant_ok;
    logic [CNT_BIT-1:0] sel_cnt;
    logic [CYC_W-1:0]   cyc_inc;
    logic               tmo_hit;

    always_comb begin
        pick1    = req1_i && (!req0_i || !last_grant);
        grant_ok = acc.acc_idle_i && (req0_i || req1_i);
        sel_cnt  = pick1 ? cnt1_i : cnt0_i;
        cyc_inc  = (cyc_cnt == CYC_MAX) ? cyc_cnt : cyc_cnt + CYC_W'(1);
        tmo_hit  = (cyc_inc >= TIMEOUT_V);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            last_grant      <= 1'b1;
            cyc_cnt         <= '0;
            ack0_o          <= 1'b0;
            ack1_o          <= 1'b0;
            done0_o         <= 1'b0;
            done1_o         <= 1'b0;
            status_o        <= ST_OK;
            cycles_o        <= '0;
            acc.acc_start_o <= 1'b0;
            acc.acc_count_o <= '0;
            busy_o          <= 1'b0;
            grant_o         <= 1'b0;
        end else begin
            ack0_o          <= 1'b0;
            ack1_o          <= 1'b0;
            done0_o         <= 1'b0;
            done1_o         <= 1'b0;
            acc.acc_start_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        acc.acc_count_o <= sel_cnt;
                        grant_o         <= pick1;
                        last_grant      <= pick1;
                        busy_o          <= 1'b1;
                        ack0_o          <= !pick1;
                        ack1_o          <= pick1;
                        if (sel_cnt != '0) begin
                            acc.acc_start_o <= 1'b1;
                            cyc_cnt         <= '0;
                            state           <= S_START;
                        end else begin
                            // Zero count is rejected without touching the accessor.
                            done0_o  <= !pick1;
                            done1_o  <= pick1;
                            status_o <= ST_ZERO;
                            cycles_o <= '0;
                            state    <= S_RESP;
                        end
                    end
                end
                S_START: begin
                    cyc_cnt <= '0;
                    state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    cyc_cnt <= cyc_inc;
                    if (acc.acc_done_i || tmo_hit) begin
                        done0_o  <= !grant_o;
                        done1_o  <= grant_o;
                        status_o <= acc.acc_done_i ? ST_OK : ST_TIMEOUT;
                        cycles_o <= cyc_inc;
                        state    <= S_RESP;
                    end else if (state == S_WAIT_BUSY && !acc.acc_idle_i) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_RESP: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accessor_scheduler.sv
// Directed bench for accessor_scheduler: table of single jobs plus hand-written
// sequences for round-robin ties, accessor busy, watchdog timeout and mid-job reset.
module tb_accessor_scheduler;

    localparam int CNT_BIT = 31;
    localparam int CYC_W   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT (default watchdog)
    logic               req0 = 1'b0, req1 = 1'b0;
    logic [CNT_BIT-1:0] cnt0 = '0, cnt1 = '0;
    logic               ack0, ack1, done0, done1, busy, grant;
    logic [1:0]         status;
    logic [CYC_W-1:0]   cycles;
    accessor_scheduler_if #(.CNT_BIT(CNT_BIT)) acc_if ();

    logic m_idle = 1'b1, m_done = 1'b0, hold_busy = 1'b0, m_run = 1'b0;
    int   m_lat = 0, m_k = 0;
    assign acc_if.acc_idle_i = m_idle & ~hold_busy;
    assign acc_if.acc_done_i = m_done;

    accessor_scheduler #(.CNT_BIT(CNT_BIT), .CYC_W(CYC_W)) dut (
        .clk(clk), .reset(reset),
        .req0_i(req0), .cnt0_i(cnt0), .ack0_o(ack0), .done0_o(done0),
        .req1_i(req1), .cnt1_i(cnt1), .ack1_o(ack1), .done1_o(done1),
        .status_o(status), .cycles_o(cycles), .acc(acc_if),
        .busy_o(busy), .grant_o(grant)
    );

    // second DUT with a short watchdog and an accessor that never finishes
    logic               t_req0 = 1'b0, t_req1 = 1'b0;
    logic [CNT_BIT-1:0] t_cnt0 = '0, t_cnt1 = '0;
    logic               t_ack0, t_ack1, t_done0, t_done1, t_busy, t_grant;
    logic [1:0]         t_status;
    logic [CYC_W-1:0]   t_cycles;
    accessor_scheduler_if #(.CNT_BIT(CNT_BIT)) t_if ();
    assign t_if.acc_idle_i = 1'b1;
    assign t_if.acc_done_i = 1'b0;

    accessor_scheduler #(.CNT_BIT(CNT_BIT), .CYC_W(CYC_W), .TIMEOUT_CYC(8)) dut_to (
        .clk(clk), .reset(reset),
        .req0_i(t_req0), .cnt0_i(t_cnt0), .ack0_o(t_ack0), .done0_o(t_done0),
        .req1_i(t_req1), .cnt1_i(t_cnt1), .ack1_o(t_ack1), .done1_o(t_done1),
        .status_o(t_status), .cycles_o(t_cycles), .acc(t_if),
        .busy_o(t_busy), .grant_o(t_grant)
    );

    // accessor model: leaves idle 1 cycle after start, done m_lat cycles after start
    always @(negedge clk) begin
        if (reset) begin
            m_run = 1'b0; m_idle = 1'b1; m_done = 1'b0;
        end else if (acc_if.acc_start_o) begin
            m_run = 1'b1; m_k = 0; m_idle = 1'b1; m_done = 1'b0;
        end else if (m_run) begin
            m_k++;
            if (m_k == 1) m_idle = 1'b0;
            if (m_lat != 0 && m_k == m_lat) m_done = 1'b1;
            if (m_lat != 0 && m_k == m_lat + 1) begin
                m_done = 1'b0; m_idle = 1'b1; m_run = 1'b0;
            end
        end
    end

    int n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0, n_start = 0, n_busy = 0, start_dbl = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (ack0)  n_ack0++;
        if (ack1)  n_ack1++;
        if (done0) n_done0++;
        if (done1) n_done1++;
        if (busy)  n_busy++;
        if (acc_if.acc_start_o) n_start++;
        if (acc_if.acc_start_o && prev_start) start_dbl++;
        prev_start = acc_if.acc_start_o;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit sig_val(input int sel);
        case (sel)
            0:       return ack0 | ack1;
            1:       return done0 | done1;
            2:       return t_ack0 | t_ack1;
            default: return t_done0 | t_done1;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int bound, input string nm, output int c);
        c = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sig_val(sel)) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no pulse within %0d cycles", nm, bound);
        end
    endtask

    typedef struct {
        logic               r0;
        logic [CNT_BIT-1:0] c0;
        logic               r1;
        logic [CNT_BIT-1:0] c1;
        int                 lat;
        logic               g;
        logic [1:0]         st;
        int                 cy;
        logic [CNT_BIT-1:0] cnt;
    } vec_t;

    vec_t vt[6];

    task automatic run_job(input vec_t v, input int idx);
        int a0, a1, d0, d1, s0, b0, tr, ca, cd;
        @(negedge clk);
        m_lat = v.lat;
        a0 = n_ack0; a1 = n_ack1; d0 = n_done0; d1 = n_done1; s0 = n_start; b0 = n_busy;
        req0 = v.r0; cnt0 = v.c0; req1 = v.r1; cnt1 = v.c1; tr = cyc;
        wait_for(0, 20, $sformatf("v%0d_ack", idx), ca);
        chk($sformatf("v%0d_ack_latency", idx), ca, tr + 1);
        chk($sformatf("v%0d_ack_owner", idx), ack1, v.g);
        chk($sformatf("v%0d_acc_count", idx), acc_if.acc_count_o, v.cnt);
        chk($sformatf("v%0d_start_at_ack", idx), acc_if.acc_start_o, v.st == 2'b00);
        req0 = 1'b0; req1 = 1'b0;
        if (done0 | done1) cd = cyc;
        else wait_for(1, v.lat + 40, $sformatf("v%0d_done", idx), cd);
        chk($sformatf("v%0d_done_latency", idx), cd, (v.st == 2'b01) ? ca : ca + v.lat + 1);
        chk($sformatf("v%0d_done_owner", idx), done1, v.g);
        chk($sformatf("v%0d_status", idx), status, v.st);
        chk($sformatf("v%0d_cycles", idx), cycles, v.cy);
        chk($sformatf("v%0d_grant", idx), grant, v.g);
        @(negedge clk);
        chk($sformatf("v%0d_n_ack0", idx), n_ack0 - a0, v.g == 1'b0);
        chk($sformatf("v%0d_n_ack1", idx), n_ack1 - a1, v.g == 1'b1);
        chk($sformatf("v%0d_n_done0", idx), n_done0 - d0, v.g == 1'b0);
        chk($sformatf("v%0d_n_done1", idx), n_done1 - d1, v.g == 1'b1);
        chk($sformatf("v%0d_n_start", idx), n_start - s0, v.st == 2'b00);
        chk($sformatf("v%0d_busy_cycles", idx), n_busy - b0, (v.st == 2'b01) ? 1 : v.lat + 2);
        chk($sformatf("v%0d_status_held", idx), status, v.st);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int ca, cd, tr, who, a0, a1, d0, d1;

        //          r0  c0            r1  c1  lat g     st     cy  cnt
        vt[0] = '{1'b1, 31'd16,      1'b0, 31'd0, 20, 1'b0, 2'b00, 20, 31'd16};
        vt[1] = '{1'b0, 31'd0,       1'b1, 31'd5,  3, 1'b1, 2'b00,  3, 31'd5};
        vt[2] = '{1'b0, 31'd0,       1'b1, 31'd0,  0, 1'b1, 2'b01,  0, 31'd0};
        vt[3] = '{1'b1, 31'd0,       1'b0, 31'd0,  0, 1'b0, 2'b01,  0, 31'd0};
        vt[4] = '{1'b1, 31'd7,       1'b1, 31'd9,  1, 1'b1, 2'b00,  1, 31'd9};
        vt[5] = '{1'b1, 31'h7FFFFFFF, 1'b1, 31'd4, 2, 1'b0, 2'b00,  2, 31'h7FFFFFFF};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_status", status, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_start", acc_if.acc_start_o, 0);
        chk("rst_count", acc_if.acc_count_o, 0);
        chk("rst_ack_done", {ack0, ack1, done0, done1}, 0);

        // round-robin ties from reset release
        a0 = n_ack0; a1 = n_ack1; d0 = n_done0; d1 = n_done1;
        m_lat = 3; cnt0 = 31'd4; cnt1 = 31'd6; req0 = 1'b1; req1 = 1'b1;
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wait_for(0, 20, "tie_ack", ca);
            who = ack1;
            chk("tie_order", who, j % 2);
            chk("tie_count", acc_if.acc_count_o, who ? 6 : 4);
            if (who != 0) req1 = 1'b0; else req0 = 1'b0;
            wait_for(1, 60, "tie_done", cd);
            chk("tie_done_owner", done1, who);
            @(negedge clk);
            if (j < 3) begin
                if (who != 0) req1 = 1'b1; else req0 = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("tie_n_ack0", n_ack0 - a0, 2);
        chk("tie_n_ack1", n_ack1 - a1, 2);
        chk("tie_n_done0", n_done0 - d0, 2);
        chk("tie_n_done1", n_done1 - d1, 2);

        for (int i = 0; i < 6; i++) run_job(vt[i], i);

        // accessor busy holds off the grant
        @(negedge clk);
        hold_busy = 1'b1; m_lat = 2; cnt0 = 31'd2; req0 = 1'b1; a0 = n_ack0;
        repeat (5) @(negedge clk);
        chk("hold_no_ack", n_ack0 - a0, 0);
        chk("hold_not_busy", busy, 0);
        hold_busy = 1'b0; tr = cyc;
        wait_for(0, 10, "hold_ack", ca);
        chk("hold_ack_latency", ca, tr + 1);
        chk("hold_ack_owner", ack0, 1);
        req0 = 1'b0;
        wait_for(1, 40, "hold_done", cd);
        chk("hold_status", status, 0);
        chk("hold_cycles", cycles, 2);

        // watchdog timeout on the short-timeout instance
        @(negedge clk);
        t_cnt0 = 31'd3; t_req0 = 1'b1; tr = cyc;
        wait_for(2, 10, "to_ack", ca);
        chk("to_ack_latency", ca, tr + 1);
        chk("to_start", t_if.acc_start_o, 1);
        chk("to_count", t_if.acc_count_o, 3);
        t_req0 = 1'b0;
        wait_for(3, 40, "to_done", cd);
        chk("to_done_after_start", cd - ca, 9);
        chk("to_done_owner", t_done0, 1);
        chk("to_status", t_status, 2);
        chk("to_cycles", t_cycles, 8);
        chk("to_grant", t_grant, 0);
        @(negedge clk);
        chk("to_idle_after", t_busy, 0);
        t_cnt1 = 31'd2; t_req1 = 1'b1; tr = cyc;
        wait_for(2, 10, "to_next_ack", ca);
        chk("to_next_ack_latency", ca, tr + 1);
        chk("to_next_ack_owner", t_ack1, 1);
        t_req1 = 1'b0;
        wait_for(3, 40, "to_next_done", cd);
        chk("to_next_done_owner", t_done1, 1);
        chk("to_next_cycles", t_cycles, 8);

        // reset during WAIT_DONE
        @(negedge clk);
        m_lat = 0; cnt0 = 31'd10; req0 = 1'b1;
        wait_for(0, 10, "mid_ack", ca);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        d0 = n_done0; d1 = n_done1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_status", status, 0);
        chk("mid_rst_cycles", cycles, 0);
        chk("mid_rst_start", acc_if.acc_start_o, 0);
        chk("mid_rst_count", acc_if.acc_count_o, 0);
        chk("mid_rst_pulses", {ack0, ack1, done0, done1}, 0);
        @(negedge clk);
        chk("mid_no_done", (n_done0 - d0) + (n_done1 - d1), 0);
        m_lat = 2; cnt0 = 31'd3; cnt1 = 31'd5; req0 = 1'b1; req1 = 1'b1;
        reset = 1'b0;
        wait_for(0, 10, "post_rst_ack0", ca);
        chk("post_rst_first_grant", ack0, 1);
        req0 = 1'b0;
        wait_for(1, 40, "post_rst_done0", cd);
        chk("post_rst_done0_owner", done0, 1);
        wait_for(0, 10, "post_rst_ack1", ca);
        chk("post_rst_second_grant", ack1, 1);
        chk("post_rst_count1", acc_if.acc_count_o, 5);
        req1 = 1'b0;
        wait_for(1, 40, "post_rst_done1", cd);
        chk("post_rst_done1_owner", done1, 1);
        chk("post_rst_cycles", cycles, 2);
        @(negedge clk);

        chk("start_pulse_width", start_dbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/accessor_scheduler.md
Name: accessor_scheduler

Overview:
Shares one BRAM accessor (accumulate/write-back datapath) between two requesters.
- Arbitrates round-robin and latches the winner's run count.
- Pulses the accessor start, then waits for the accessor's done.
- Returns a done pulse with status and elapsed cycles to the owning requester.
- A watchdog aborts jobs whose accessor done never arrives.

Parameters:
CNT_BIT, 31, width of run count (matches accessor run_count_i)
CYC_W, 16, width of elapsed-cycle counter/report
TIMEOUT_CYC, 1024, wait-state cycles before a job is aborted (must be < 2^CYC_W)

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
req0_i  in  1  requester 0 request; held high with stable cnt0_i until ack0_o
cnt0_i  in  CNT_BIT  requester 0 run count
ack0_o  out  1  one-cycle pulse: request 0 accepted
done0_o  out  1  one-cycle pulse: job of requester 0 finished
req1_i  in  1  requester 1 request
cnt1_i  in  CNT_BIT  requester 1 run count
ack1_o  out  1  one-cycle pulse: request 1 accepted
done1_o  out  1  one-cycle pulse: job of requester 1 finished
status_o  out  2  00 ok, 01 zero count (rejected), 10 timeout; valid with doneX_o, held until the next done
cycles_o  out  CYC_W  wait-state cycles of the last job (saturating); valid with doneX_o, held
acc_idle_i  in  1  accessor idle state
acc_done_i  in  1  accessor done state
acc_start_o  out  1  one-cycle start pulse to accessor start_run_i
acc_count_o  out  CNT_BIT  run count to accessor; stable from START through RESP
busy_o  out  1  high in every state except IDLE
grant_o  out  1  owner of the current or last job (0/1)

Behaviour:
- All outputs are registered. Reset drives every output to 0, the state to IDLE, the watchdog/cycle counter to 0, and last_grant to 1, so req0 wins the first tie.
- Reset asserted mid-job: same result. The accessor is not notified; no done pulse is issued for the aborted job.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: grant only when acc_idle_i=1 and at least one reqX_i=1.
  - If both requests are high, grant the requester != last_grant. If one is high, grant it.
  - On grant: latch the count into acc_count_o, set grant_o and last_grant.
  - Count != 0: next state START.
  - Count == 0: next state RESP with status 01, cycles 0, no accessor start, and ackX_o is pulsed in that RESP cycle.
- START (1 cycle): ackX_o=1, acc_start_o=1, counter cleared to 0. Next state WAIT_BUSY.
- WAIT_BUSY: counter increments each cycle (saturating at 2^CYC_W-1).
  - acc_done_i=1 → RESP, status 00.
  - Else acc_idle_i=0 → WAIT_DONE.
- WAIT_DONE: counter increments.
  - acc_done_i=1 → RESP, status 00.
- Timeout: in either wait state, the counter reaching TIMEOUT_CYC with no acc_done_i → RESP, status 10.
  - acc_done_i on that same edge takes priority: status 00.
- RESP (1 cycle): doneX_o=1 for grant_o. status_o and cycles_o are updated this cycle (cycles = counter value). Next state IDLE.
- Latency:
  - req sampled at edge n → ack/start high in cycle n+1.
  - acc_done_i sampled at edge m → done pulse in cycle m+1.
  - Minimum back-to-back job gap: one IDLE cycle.
- A requester must drop reqX_i after its ack. A request still high in IDLE is treated as a new job.
- Requests arriving while busy_o=1 are held off, not queued. Only the first IDLE cycle with both requests high decides priority.
- acc_count_o keeps its last value in IDLE until the next grant.

Test Plan:
- Single job: req0=1, cnt0=16; accessor model leaves idle 1 cycle after start and asserts done 20 cycles after start → ack0 one cycle after req sampled; acc_start pulse width 1; acc_count_o=16; done0 one cycle after acc_done; status 00; cycles_o=20; done1/ack1 never pulse.
- Tie round-robin: req0 and req1 both high from reset release, each re-raised after its done → grant order 0,1,0,1; each ack and each done once per job.
- Zero count: req1=1, cnt1=0 → ack1 and done1 in the same cycle, status 01, cycles 0, acc_start_o never high, busy_o high exactly 1 cycle.
- Timeout: TIMEOUT_CYC=8, accessor never asserts done → done0 with status 10 and cycles_o=8 exactly 9 cycles after the START cycle (8 wait cycles, then RESP); then IDLE, and the next request is accepted.
- Accessor busy: acc_idle_i=0 while req0=1 → no ack; ack0 follows one cycle after acc_idle_i returns to 1.
- Reset mid-job: assert reset during WAIT_DONE → next cycle all outputs 0, busy_o=0, no done pulse; after release, simultaneous req0/req1 → req0 granted first.
